button_debounce: RTL and testbench

- Upstream conditioning stage for the single-pulse generator.
- Takes a raw, asynchronous, bouncing push-button level, synchronizes it into the clk domain and filters bounce.
- Drives a clean level `ub` that feeds the single-pulse generator's `ub` input directly.
- Guarantees `ub` only changes after the synchronized input has been stable for STABLE_CYCLES consecutive clocks.

---
 rtl/button_debounce_pkg.sv | 13 +
 rtl/button_debounce_sync_ff.sv | 23 ++
 rtl/button_debounce.sv | 109 ++++++++++
 tb/tb_button_debounce.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared encodings for the push-button debouncer: FSM states and glitch counter width.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    localparam int GLITCH_W = 8;

endpackage

// File: rtl/button_debounce_sync_ff.sv
// Multi-stage synchronizer bringing an asynchronous level into the clk domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_l,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes btn_raw and only moves ub after a stable run.
// Optional glitch counter port enabled by defining BUTTON_DEBOUNCE_GLITCH_CNT_EN.
module button_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                btn_raw,
    output logic                ub
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ub_n;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_l (rst_l),
        .d     (btn_raw),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= S_LOW;
            cnt   <= '0;
            ub    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ub    <= ub_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ub_n    = ub;
        case (state)
            S_LOW: begin
                if (s) begin
                    state_n = S_RISE;
                    cnt_n   = '0;
                end
            end
            S_RISE: begin
                if (!s) begin
                    state_n = S_LOW;
                end else if (cnt == CNT_MAX) begin
                    state_n = S_HIGH;
                    ub_n    = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_n = S_FALL;
                    cnt_n   = '0;
                end
            end
            S_FALL: begin
                if (s) begin
                    state_n = S_HIGH;
                end else if (cnt == CNT_MAX) begin
                    state_n = S_LOW;
                    ub_n    = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                // Corrupted encoding: fall back to the released-button state.
                state_n = S_LOW;
                cnt_n   = '0;
                ub_n    = 1'b0;
            end
        endcase
    end

`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
    logic glitch;

    // A glitch is a level that reverts before the stability run completes.
    always_comb begin
        glitch = ((state == S_RISE) && !s) || ((state == S_FALL) && s);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            glitch_cnt <= '0;
        end else if (glitch && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomized and directed bench for button_debounce with a history-based reference model.
module tb_button_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int CW     = 3;
    localparam int DEPTH  = SYNC + STABLE + 1;
    localparam int LAT    = SYNC + STABLE;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    logic btn_raw = 1'b0;
    logic ub;
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    // reference model: raw samples per edge, newest at index 0
    logic       hist [DEPTH];
    logic       m_ub;
    int         m_gcnt;
    logic [0:0] exp_q [$];
    logic [7:0] gexp_q [$];

    button_debounce #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .btn_raw    (btn_raw),
        .ub         (ub)
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // The FSM at edge n reads the raw level sampled SYNC edges earlier. ub flips
    // once STABLE+1 consecutive reads all disagree with it; a read that returns to
    // ub right after a disagreeing read is a rejected glitch.
    task automatic model_step();
        bit run_ok;
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) hist[i] = 1'b0;
            m_ub   = 1'b0;
            m_gcnt = 0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = btn_raw;
            if (hist[SYNC] == m_ub && hist[SYNC+1] != m_ub && m_gcnt < 255) m_gcnt++;
            run_ok = 1'b1;
            for (int i = SYNC; i <= SYNC + STABLE; i++) if (hist[i] == m_ub) run_ok = 1'b0;
            if (run_ok) m_ub = ~m_ub;
        end
        exp_q.push_back(m_ub);
        gexp_q.push_back(m_gcnt[7:0]);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) hist[i] = 1'b0;
        m_ub   = 1'b0;
        m_gcnt = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [0:0] e;
        logic [7:0] ge;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ge = gexp_q.pop_front();
                n_checks++;
                if (ub !== e[0]) begin
                    n_fail++;
                    $display("FAIL ub_level: got %b expected %b at %0t", ub, e[0], $time);
                end
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
                n_checks++;
                if (glitch_cnt !== ge) begin
                    n_fail++;
                    $display("FAIL glitch_cnt: got %0d expected %0d at %0t", glitch_cnt, ge, $time);
                end
`endif
            end
        end
    end

    // downstream single-pulse generator stand-in: counts rising edges of ub
    initial begin
        logic ub_prev;
        ub_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ub === 1'b1 && ub_prev === 1'b0) pulses++;
            ub_prev = ub;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic b, input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            btn_raw = b;
        end
    endtask

    // level already applied just after a negedge; count edges until ub reaches target
    task automatic measure(input string name, input logic target);
        int n;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (ub === target) break;
        end
        check(name, n - 1, LAT);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        check("reset_async_ub", int'(ub), 0);
        repeat (n) @(negedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        logic lvl;
        rst_l   = 1'b0;
        btn_raw = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ub", int'(ub), 0);
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
        check("reset_glitch_cnt", int'(glitch_cnt), 0);
`endif
        #1;
        rst_l = 1'b1;
        drive(1'b0, 5);

        // clean press and release
        drive(1'b1, 1);
        measure("press_latency", 1'b1);
        drive(1'b1, 6);
        check("press_hold", int'(ub), 1);
        drive(1'b0, 1);
        measure("release_latency", 1'b0);
        drive(1'b0, 4);

        // bounce on press, then release with a one-cycle bounce back
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 1);
        drive(1'b1, 12);
        check("bounce_press_ub", int'(ub), 1);
        drive(1'b0, 1); drive(1'b1, 1);
        drive(1'b0, 1);
        measure("bounce_release_latency", 1'b0);
        drive(1'b0, 4);

        // short pulse never reaches ub
        drive(1'b1, 3);
        drive(1'b0, 10);
        check("short_pulse_ub", int'(ub), 0);

        // reset while qualifying a press, then full re-qualification
        drive(1'b1, 4);
        pulse_reset(2);
        measure("post_reset_latency", 1'b1);
        drive(1'b1, 3);
        // reset while ub is high must drop it immediately
        pulse_reset(1);
        drive(1'b0, 8);

        // bouncy press held long gives exactly one downstream pulse
        p0 = pulses;
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 2); drive(1'b0, 1);
        drive(1'b1, 50);
        check("single_pulse_count", pulses - p0, 1);
        drive(1'b0, 10);

        // glitch storm to drive the glitch counter into saturation
        pulse_reset(1);
        repeat (300) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
        end
        drive(1'b0, 4);
        check("storm_ub", int'(ub), 0);

        // randomized segments with occasional resets
        for (int seg = 0; seg < 400; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) drive(lvl, $urandom_range(5, 12));
            else                           drive(lvl, $urandom_range(1, 4));
            if ($urandom_range(0, 59) == 0) pulse_reset($urandom_range(1, 3));
        end
        drive(1'b0, 12);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
